// File: rtl/digital_clock_mux.sv
// digital_clock_mux: HH:MM:SS real-time clock with a multiplexed seven-segment driver.
// A 1 Hz tick-enable is derived from clk by a prescaler; no derived clocks.
// Optional macro ALARM_EN adds an HH:MM alarm compare (alarm_time, alarm_on, alarm).
`timescale 1ns/1ps
module digital_clock_mux #(
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_mode,
    input  logic                  inc_min,
    input  logic                  inc_hr,
    input  logic                  mode_12h,
    output logic [6:0]            SSD,
    output logic [NUM_DIGITS-1:0] EN,
    output logic                  pm,
`ifdef ALARM_EN
    input  logic [15:0]           alarm_time,
    input  logic                  alarm_on,
    output logic                  alarm,
`endif
    output logic                  tick
);

    localparam int unsigned PW       = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned DIG_OFS  = (NUM_DIGITS == 4) ? 2 : 0;
    localparam logic [2:0]  IDX_MAX  = 3'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    logic [PW-1:0]           presc;
    logic [REFRESH_BITS-1:0] scan_cnt;
    logic [2:0]              dig_idx;
    logic [7:0]              sec_q, min_q, hr_q;
    logic [7:0]              sec_n, min_n, hr_n;
    logic                    tick_c;
    logic [7:0]              hr_disp;
    logic [3:0]              ht_disp;
    logic [2:0]              lidx;
    logic [3:0]              digit_val;

    // BCD 00..59 increment
    function automatic logic [7:0] inc60(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {(v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // BCD 00..23 increment
    function automatic logic [7:0] inc24(input logic [7:0] v);
        if (v == 8'h23)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 is blank
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Next time value: set-mode increments or run-mode seconds carry chain
    always_comb begin
        sec_n  = sec_q;
        min_n  = min_q;
        hr_n   = hr_q;
        tick_c = 1'b0;
        if (set_mode) begin
            sec_n = 8'h00;
            if (inc_min) min_n = inc60(min_q);
            if (inc_hr)  hr_n  = inc24(hr_q);
        end else if (presc == PRESC_MAX) begin
            tick_c = 1'b1;
            sec_n  = inc60(sec_q);
            if (sec_q == 8'h59) begin
                min_n = inc60(min_q);
                if (min_q == 8'h59) hr_n = inc24(hr_q);
            end
        end
    end

    // Prescaler, tick pulse, time registers and pm flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            tick  <= 1'b0;
            sec_q <= 8'h00;
            min_q <= 8'h00;
            hr_q  <= 8'h00;
            pm    <= 1'b0;
        end else begin
            presc <= (set_mode || tick_c) ? '0 : presc + PW'(1);
            tick  <= tick_c;
            sec_q <= sec_n;
            min_q <= min_n;
            hr_q  <= hr_n;
            pm    <= (hr_n >= 8'h12);
        end
    end

    // 12-hour display conversion of the internal 24-hour value
    always_comb begin
        hr_disp = hr_q;
        if (mode_12h) begin
            if (hr_q == 8'h00)      hr_disp = 8'h12;
            else if (hr_q >= 8'h22) hr_disp = {4'h1, hr_q[3:0] - 4'd2};
            else if (hr_q >= 8'h20) hr_disp = {4'h0, hr_q[3:0] + 4'd8};
            else if (hr_q >= 8'h13) hr_disp = {4'h0, hr_q[3:0] - 4'd2};
        end
    end

    assign ht_disp = (mode_12h && hr_disp[7:4] == 4'h0) ? 4'hF : hr_disp[7:4];
    assign lidx    = dig_idx + 3'(DIG_OFS);

    // Select the digit value for the current scan position
    always_comb begin
        digit_val = 4'hF;
        case (lidx)
            3'd0:    digit_val = sec_q[3:0];
            3'd1:    digit_val = sec_q[7:4];
            3'd2:    digit_val = min_q[3:0];
            3'd3:    digit_val = min_q[7:4];
            3'd4:    digit_val = hr_disp[3:0];
            3'd5:    digit_val = ht_disp;
            default: digit_val = 4'hF;
        endcase
    end

    // Scan counter, digit index and display load one cycle after each index change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            dig_idx  <= 3'd0;
            SSD      <= 7'h7F;
            EN       <= '1;
        end else begin
            scan_cnt <= scan_cnt + REFRESH_BITS'(1);
            if (scan_cnt == '1)
                dig_idx <= (dig_idx == IDX_MAX) ? 3'd0 : dig_idx + 3'd1;
            if (scan_cnt == '0) begin
                SSD <= seg7(digit_val);
                EN  <= ~(NUM_DIGITS'(1) << dig_idx);
            end
        end
    end

`ifdef ALARM_EN
    // Alarm tracks the time value being loaded so it aligns with the minute change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            alarm <= 1'b0;
        else
            alarm <= alarm_on && !set_mode && ({hr_n, min_n} == alarm_time);
    end
`endif

endmodule

// File: tb/tb_digital_clock_mux.sv
// Directed bench for digital_clock_mux (CLK_HZ=4, REFRESH_BITS=2, NUM_DIGITS=6).
`timescale 1ns/1ps
module tb_digital_clock_mux;

    localparam int unsigned CLK_HZ       = 4;
    localparam int unsigned NUM_DIGITS   = 6;
    localparam int unsigned REFRESH_BITS = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       set_mode, inc_min, inc_hr, mode_12h;
    logic [6:0] SSD;
    logic [5:0] EN;
    logic       pm, tick;
`ifdef ALARM_EN
    logic [15:0] alarm_time;
    logic        alarm_on;
    logic        alarm;
`endif

    int checks = 0;
    int errors = 0;

    digital_clock_mux #(
        .CLK_HZ(CLK_HZ), .NUM_DIGITS(NUM_DIGITS), .REFRESH_BITS(REFRESH_BITS)
    ) dut (
        .clk(clk), .rst(rst), .set_mode(set_mode), .inc_min(inc_min),
        .inc_hr(inc_hr), .mode_12h(mode_12h), .SSD(SSD), .EN(EN), .pm(pm),
`ifdef ALARM_EN
        .alarm_time(alarm_time), .alarm_on(alarm_on), .alarm(alarm),
`endif
        .tick(tick)
    );

    always #5 clk = ~clk;

    wire [23:0] cur_time = {dut.hr_q, dut.min_q, dut.sec_q};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic pulse_min(input int n);
        for (int i = 0; i < n; i++) begin
            inc_min = 1'b1;
            @(negedge clk);
            inc_min = 1'b0;
        end
    endtask

    task automatic pulse_hr(input int n);
        for (int i = 0; i < n; i++) begin
            inc_hr = 1'b1;
            @(negedge clk);
            inc_hr = 1'b0;
        end
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < 16);
        if (tick !== 1'b1) check({tag, "_timeout"}, 32'(tick), 32'd1);
    endtask

    task automatic wait_ticks(input int cnt, input string tag);
        for (int i = 0; i < cnt; i++) wait_tick(tag);
    endtask

    // Wait for a fresh load of digit position pos and return its segments
    task automatic read_digit(input int pos, output logic [6:0] seg);
        logic [5:0] want;
        int n = 0;
        want = ~(6'b000001 << pos);
        while (EN === want && n < 64) begin @(negedge clk); n++; end
        while (EN !== want && n < 64) begin @(negedge clk); n++; end
        if (EN !== want) check("scan_timeout", 32'(EN), 32'(want));
        seg = SSD;
    endtask

    initial begin
        logic [6:0] seg;
        logic [5:0] exp_en;
        int         n;

        rst = 1'b0; set_mode = 1'b0; inc_min = 1'b0; inc_hr = 1'b0; mode_12h = 1'b0;
`ifdef ALARM_EN
        alarm_time = 16'h0000; alarm_on = 1'b0;
`endif
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_en",   32'(EN),   32'h3F);
        check("rst_ssd",  32'(SSD),  32'h7F);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_pm",   32'(pm),   32'd0);
        check("rst_time", 32'(cur_time), 32'h000000);
`ifdef ALARM_EN
        check("rst_alarm", 32'(alarm), 32'd0);
`endif

        // Scan order: one digit per 4 cycles, wrapping after six
        rst = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            exp_en = ~(6'b000001 << (k % 6));
            check("en_scan", 32'(EN), 32'(exp_en));
            if (k == 0) check("ssd_first", 32'(SSD), 32'h40);
            repeat (3) @(negedge clk);
        end

        // Tick every CLK_HZ cycles; 60 ticks reach 00:01:00
        do_reset();
        n = 0;
        for (int i = 1; i <= 240; i++) begin
            @(negedge clk);
            if (i <= 8) check("tick_period", 32'(tick), 32'((i % 4) == 0));
            if (tick === 1'b1) n++;
        end
        check("tick_count", 32'(n), 32'd60);
        check("time_1min", 32'(cur_time), 32'h000100);

        // Set to 23:59, run to 23:59:59 then wrap to midnight
        do_reset();
        set_mode = 1'b1;
        @(negedge clk);
        pulse_hr(23);
        pulse_min(59);
        check("set_2359", 32'(cur_time), 32'h235900);
        check("set_pm", 32'(pm), 32'd1);
        check("set_tick", 32'(tick), 32'd0);
        set_mode = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("first_tick", 32'(tick), 32'(i == 4));
        end
        wait_ticks(58, "run59");
        check("time_235959", 32'(cur_time), 32'h235959);
        check("pm_before_wrap", 32'(pm), 32'd1);
        wait_tick("wrap");
        check("time_wrap", 32'(cur_time), 32'h000000);
        check("pm_after_wrap", 32'(pm), 32'd0);

        // Simultaneous increments without carry, modulo wraps, ignored in run mode
        set_mode = 1'b1;
        @(negedge clk);
        pulse_min(59);
        inc_min = 1'b1; inc_hr = 1'b1;
        @(negedge clk);
        inc_min = 1'b0; inc_hr = 1'b0;
        check("both_inc", 32'(cur_time), 32'h010000);
        pulse_min(60);
        check("min_mod60", 32'(cur_time), 32'h010000);
        pulse_hr(23);
        check("hr_mod24", 32'(cur_time), 32'h000000);
        set_mode = 1'b0;
        pulse_min(1);
        pulse_hr(1);
        check("inc_ignored", 32'(cur_time[23:8]), 32'h0000);

        // 12-hour display conversion and leading blank
        set_mode = 1'b1;
        mode_12h = 1'b1;
        @(negedge clk);
        read_digit(5, seg); check("h12_00_tens", 32'(seg), 32'h79);
        read_digit(4, seg); check("h12_00_ones", 32'(seg), 32'h24);
        read_digit(2, seg); check("min_ones_0",  32'(seg), 32'h40);
        check("pm_00", 32'(pm), 32'd0);
        pulse_hr(13);
        read_digit(5, seg); check("h12_13_tens", 32'(seg), 32'h7F);
        read_digit(4, seg); check("h12_13_ones", 32'(seg), 32'h79);
        check("pm_13", 32'(pm), 32'd1);
        mode_12h = 1'b0;
        read_digit(5, seg); check("h24_13_tens", 32'(seg), 32'h79);
        read_digit(4, seg); check("h24_13_ones", 32'(seg), 32'h30);
        check("pm_13_24h", 32'(pm), 32'd1);
        mode_12h = 1'b1;
        pulse_hr(9);
        read_digit(5, seg); check("h12_22_tens", 32'(seg), 32'h79);
        read_digit(4, seg); check("h12_22_ones", 32'(seg), 32'h40);
        mode_12h = 1'b0;

        // Asynchronous reset mid-count at 12:34:56
        pulse_hr(14);
        pulse_min(34);
        set_mode = 1'b0;
        wait_ticks(56, "to123456");
        check("time_123456", 32'(cur_time), 32'h123456);
        repeat (2) @(negedge clk);
        check("en_onehot", 32'($countones(~EN)), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_en",   32'(EN),   32'h3F);
        check("arst_ssd",  32'(SSD),  32'h7F);
        check("arst_time", 32'(cur_time), 32'h000000);
        check("arst_pm",   32'(pm),   32'd0);
        check("arst_tick", 32'(tick), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("resume_en", 32'(EN), 32'h3E);
        repeat (3) @(negedge clk);
        check("resume_tick", 32'(tick), 32'd1);
        check("resume_time", 32'(cur_time), 32'h000001);

`ifdef ALARM_EN
        // Alarm high for the matching minute, drops on minute change or disarm
        do_reset();
        alarm_on   = 1'b1;
        alarm_time = 16'h0001;
        wait_ticks(59, "al59");
        check("alarm_pre", 32'(alarm), 32'd0);
        wait_tick("al60");
        check("alarm_rise", 32'(alarm), 32'd1);
        check("alarm_time", 32'(cur_time), 32'h000100);
        wait_ticks(59, "al119");
        check("alarm_hold", 32'(alarm), 32'd1);
        wait_tick("al120");
        check("alarm_fall", 32'(alarm), 32'd0);
        alarm_time = 16'h0002;
        @(negedge clk);
        check("alarm_rearm", 32'(alarm), 32'd1);
        alarm_on = 1'b0;
        @(negedge clk);
        check("alarm_off", 32'(alarm), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
